// File: rtl/pcie_tlp_pkg.sv
// Shared types and width defaults for the PCIe TLP request arbiter.
// Used by pcie_tlp_req_arb and rr_select.
package pcie_tlp_pkg;

   localparam int unsigned DEF_PORTS      = 4;
   localparam int unsigned DEF_DATA_WIDTH = 256;
   localparam int unsigned DEF_STRB_WIDTH = 8;
   localparam int unsigned DEF_HDR_WIDTH  = 128;
   localparam int unsigned CNT_WIDTH      = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// Round-robin requester pick: the first asserted request strictly after
// last_grant (wrapping at PORTS) wins; the grant is one-hot.
module rr_select
   import pcie_tlp_pkg::*;
#(
   parameter int unsigned PORTS = DEF_PORTS,
   parameter int unsigned IDW   = $clog2(PORTS)
) (
   input  logic [PORTS-1:0] req,
   input  logic [IDW-1:0]   last_grant,
   output logic [PORTS-1:0] grant
);

   always_comb begin
      logic [IDW-1:0] idx;
      logic           found;
      grant = '0;
      found = 1'b0;
      idx   = last_grant;
      for (int unsigned k = 0; k < PORTS; k++) begin
         idx = (idx == IDW'(PORTS - 1)) ? '0 : idx + 1'b1;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/pcie_tlp_req_arb.sv
// Packet-atomic round-robin arbiter of PORTS TLP request sources onto one rx_req stream.
// Optional per-port completed-packet counters (pkt_cnt) with PCIE_TLP_ARB_PKT_CNT_EN.
module pcie_tlp_req_arb
   import pcie_tlp_pkg::*;
#(
   parameter int unsigned PORTS          = DEF_PORTS,
   parameter int unsigned TLP_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned TLP_STRB_WIDTH = DEF_STRB_WIDTH,
   parameter int unsigned TLP_HDR_WIDTH  = DEF_HDR_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PORTS*TLP_DATA_WIDTH-1:0]  s_tlp_data,
   input  logic [PORTS*TLP_STRB_WIDTH-1:0]  s_tlp_strb,
   input  logic [PORTS*TLP_HDR_WIDTH-1:0]   s_tlp_hdr,
   input  logic [PORTS-1:0]                 s_tlp_valid,
   input  logic [PORTS-1:0]                 s_tlp_sop,
   input  logic [PORTS-1:0]                 s_tlp_eop,
   output logic [PORTS-1:0]                 s_tlp_ready,
   output logic [TLP_DATA_WIDTH-1:0]        m_tlp_data,
   output logic [TLP_STRB_WIDTH-1:0]        m_tlp_strb,
   output logic [TLP_HDR_WIDTH-1:0]         m_tlp_hdr,
   output logic                             m_tlp_valid,
   output logic                             m_tlp_sop,
   output logic                             m_tlp_eop,
   input  logic                             m_tlp_ready,
   output logic [$clog2(PORTS)-1:0]         grant_id,
   output logic                             grant_active,
   output logic                             sop_err
`ifdef PCIE_TLP_ARB_PKT_CNT_EN
   ,
   output logic [PORTS*CNT_WIDTH-1:0]       pkt_cnt
`endif
);

   localparam int unsigned IDW = $clog2(PORTS);

   arb_state_t           state;
   logic [IDW-1:0]       last_grant;
   logic [IDW-1:0]       sel_id;
   logic [PORTS-1:0]     sel_onehot;
   logic                 first_beat;
   logic                 xfer;

   logic [TLP_DATA_WIDTH-1:0] data_a [PORTS];
   logic [TLP_STRB_WIDTH-1:0] strb_a [PORTS];
   logic [TLP_HDR_WIDTH-1:0]  hdr_a  [PORTS];

   for (genvar g = 0; g < PORTS; g++) begin : g_split
      assign data_a[g] = s_tlp_data[g*TLP_DATA_WIDTH +: TLP_DATA_WIDTH];
      assign strb_a[g] = s_tlp_strb[g*TLP_STRB_WIDTH +: TLP_STRB_WIDTH];
      assign hdr_a[g]  = s_tlp_hdr[g*TLP_HDR_WIDTH +: TLP_HDR_WIDTH];
   end

   rr_select #(
      .PORTS (PORTS),
      .IDW   (IDW)
   ) u_rr_select (
      .req        (s_tlp_valid),
      .last_grant (last_grant),
      .grant      (sel_onehot)
   );

   always_comb begin
      sel_id = '0;
      for (int unsigned i = 0; i < PORTS; i++) begin
         if (sel_onehot[i]) sel_id = IDW'(i);
      end
   end

   // Outputs are forced to zero while idle so the sink never sees a stale beat.
   always_comb begin
      m_tlp_data  = '0;
      m_tlp_strb  = '0;
      m_tlp_hdr   = '0;
      m_tlp_valid = 1'b0;
      m_tlp_sop   = 1'b0;
      m_tlp_eop   = 1'b0;
      s_tlp_ready = '0;
      if (state == LOCKED) begin
         m_tlp_data            = data_a[grant_id];
         m_tlp_strb            = strb_a[grant_id];
         m_tlp_hdr             = hdr_a[grant_id];
         m_tlp_valid           = s_tlp_valid[grant_id];
         m_tlp_sop             = s_tlp_sop[grant_id];
         m_tlp_eop             = s_tlp_eop[grant_id];
         s_tlp_ready[grant_id] = m_tlp_ready;
      end
   end

   assign xfer = m_tlp_valid && m_tlp_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         grant_id     <= '0;
         grant_active <= 1'b0;
         last_grant   <= IDW'(PORTS - 1);
         first_beat   <= 1'b0;
         sop_err      <= 1'b0;
      end else begin
         sop_err <= 1'b0;
         if (state == IDLE) begin
            if (|s_tlp_valid) begin
               state        <= LOCKED;
               grant_id     <= sel_id;
               grant_active <= 1'b1;
               first_beat   <= 1'b1;
            end
         end else if (xfer) begin
            // sop must be set on the first beat of a grant and only there
            first_beat <= 1'b0;
            sop_err    <= first_beat ? !m_tlp_sop : m_tlp_sop;
            if (m_tlp_eop) begin
               state        <= IDLE;
               grant_active <= 1'b0;
               last_grant   <= grant_id;
            end
         end
      end
   end

`ifdef PCIE_TLP_ARB_PKT_CNT_EN
   logic [CNT_WIDTH-1:0] cnt_a [PORTS];

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_a <= '{default: '0};
      end else if (xfer && m_tlp_eop && (cnt_a[grant_id] != '1)) begin
         cnt_a[grant_id] <= cnt_a[grant_id] + 1'b1;
      end
   end

   for (genvar g = 0; g < PORTS; g++) begin : g_cnt
      assign pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_a[g];
   end
`endif

endmodule

// File: tb/tb_pcie_tlp_req_arb.sv
// Scoreboard bench for pcie_tlp_req_arb: stimulus + packet-level reference model push
// expectations, a negedge monitor pops and compares. Honours PCIE_TLP_ARB_PKT_CNT_EN.
module tb_pcie_tlp_req_arb;

   localparam int P   = 4;
   localparam int DW  = 32;
   localparam int SW  = 4;
   localparam int HW  = 32;
   localparam int IDW = 2;
   localparam int CW  = 16;
   localparam int SBW = P + IDW + 4;
   localparam int BW  = DW + SW + HW + 2 + IDW;

   typedef logic [IDW-1:0] pid_t;

   typedef struct {
      logic [P-1:0]         rdy;
      logic                 vld;
      logic                 act;
      pid_t                 gid;
      logic                 err;
      logic [P-1:0][CW-1:0] cnt;
   } stat_t;

   typedef struct {
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      logic [HW-1:0] h;
      logic          sop;
      logic          eop;
      pid_t          gid;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [P-1:0][DW-1:0] sd = '0;
   logic [P-1:0][SW-1:0] ss = '0;
   logic [P-1:0][HW-1:0] sh = '0;
   logic [P-1:0] s_tlp_valid = '0;
   logic [P-1:0] s_tlp_sop   = '0;
   logic [P-1:0] s_tlp_eop   = '0;
   logic [P-1:0] s_tlp_ready;
   logic [DW-1:0] m_tlp_data;
   logic [SW-1:0] m_tlp_strb;
   logic [HW-1:0] m_tlp_hdr;
   logic m_tlp_valid, m_tlp_sop, m_tlp_eop;
   logic m_tlp_ready = 1'b0;
   pid_t grant_id;
   logic grant_active, sop_err;
`ifdef PCIE_TLP_ARB_PKT_CNT_EN
   logic [P*CW-1:0] pkt_cnt;
`endif

   always #5 clk = ~clk;

   pcie_tlp_req_arb #(
      .PORTS          (P),
      .TLP_DATA_WIDTH (DW),
      .TLP_STRB_WIDTH (SW),
      .TLP_HDR_WIDTH  (HW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_tlp_data   (sd),
      .s_tlp_strb   (ss),
      .s_tlp_hdr    (sh),
      .s_tlp_valid  (s_tlp_valid),
      .s_tlp_sop    (s_tlp_sop),
      .s_tlp_eop    (s_tlp_eop),
      .s_tlp_ready  (s_tlp_ready),
      .m_tlp_data   (m_tlp_data),
      .m_tlp_strb   (m_tlp_strb),
      .m_tlp_hdr    (m_tlp_hdr),
      .m_tlp_valid  (m_tlp_valid),
      .m_tlp_sop    (m_tlp_sop),
      .m_tlp_eop    (m_tlp_eop),
      .m_tlp_ready  (m_tlp_ready),
      .grant_id     (grant_id),
      .grant_active (grant_active),
      .sop_err      (sop_err)
`ifdef PCIE_TLP_ARB_PKT_CNT_EN
      ,
      .pkt_cnt      (pkt_cnt)
`endif
   );

   int total = 0;
   int bad   = 0;

   stat_t stat_q[$];
   beat_t beat_q[$];

   // source state: one packet in flight per port
   bit            src_on  [P];
   bit            src_badf[P];
   bit            src_badm[P];
   int unsigned   src_len [P];
   int unsigned   src_idx [P];
   logic [DW-1:0] cur_d   [P];
   logic [SW-1:0] cur_s   [P];
   logic [HW-1:0] cur_h   [P];

   int unsigned drop_pct = 0;
   int unsigned rdy_pct  = 100;
   int unsigned auto_pct = 0;
   int unsigned auto_max = 1;
   int unsigned rdy_low  = 0;
   bit          rst_cmd  = 1'b1;

   // reference model: who owns the output stream and whose turn is next
   bit          md_locked = 1'b0;
   pid_t        md_owner  = '0;
   pid_t        md_last   = pid_t'(P - 1);
   bit          md_first  = 1'b0;
   bit          md_err    = 1'b0;
   int unsigned md_cnt[P];

   task automatic new_beat(input int p);
      cur_d[p] = $urandom;
      cur_s[p] = SW'($urandom);
      cur_h[p] = $urandom;
   endtask

   task automatic start_pkt(input int p, input int unsigned len, input bit badf, input bit badm);
      src_on[p]   = 1'b1;
      src_len[p]  = len;
      src_idx[p]  = 0;
      src_badf[p] = badf;
      src_badm[p] = badm;
      new_beat(p);
   endtask

   task automatic model();
      stat_t st;
      beat_t b;
      bit    x;
      bit    nerr;
      int    o;
      o      = int'(md_owner);
      st.rdy = '0;
      st.vld = 1'b0;
      st.act = md_locked;
      st.gid = md_owner;
      st.err = md_err;
      for (int i = 0; i < P; i++) st.cnt[pid_t'(i)] = CW'(md_cnt[i]);
      if (md_locked) begin
         st.vld           = s_tlp_valid[md_owner];
         st.rdy[md_owner] = m_tlp_ready;
      end
      stat_q.push_back(st);

      x = md_locked && s_tlp_valid[md_owner] && m_tlp_ready;
      if (x) begin
         b.d   = sd[md_owner];
         b.s   = ss[md_owner];
         b.h   = sh[md_owner];
         b.sop = s_tlp_sop[md_owner];
         b.eop = s_tlp_eop[md_owner];
         b.gid = md_owner;
         beat_q.push_back(b);
         src_idx[o]++;
         if (src_idx[o] >= src_len[o]) src_on[o] = 1'b0;
         else new_beat(o);
      end
      nerr = x && (md_first ? !s_tlp_sop[md_owner] : s_tlp_sop[md_owner]);

      if (rst) begin
         md_locked = 1'b0;
         md_owner  = '0;
         md_last   = pid_t'(P - 1);
         md_first  = 1'b0;
         md_err    = 1'b0;
         for (int i = 0; i < P; i++) begin
            md_cnt[i] = 0;
            src_on[i] = 1'b0;
         end
      end else begin
         md_err = nerr;
         if (!md_locked) begin
            for (int k = 1; k <= P; k++) begin
               pid_t c;
               c = pid_t'((int'(md_last) + k) % P);
               if (s_tlp_valid[c]) begin
                  md_owner  = c;
                  md_locked = 1'b1;
                  md_first  = 1'b1;
                  break;
               end
            end
         end else if (x) begin
            md_first = 1'b0;
            if (b.eop) begin
               md_locked = 1'b0;
               md_last   = md_owner;
               if (md_cnt[o] < 65535) md_cnt[o]++;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < P; i++) begin
         if (!src_on[i] && auto_pct != 0 && $urandom_range(99) < auto_pct)
            start_pkt(i, $urandom_range(auto_max, 1), ($urandom_range(15) == 0), ($urandom_range(15) == 0));
      end
      rst = rst_cmd;
      for (int i = 0; i < P; i++) begin
         pid_t p;
         p              = pid_t'(i);
         s_tlp_valid[p] = src_on[i] && ($urandom_range(99) >= drop_pct);
         s_tlp_sop[p]   = (src_idx[i] == 0) ? !src_badf[i] : (src_badm[i] && src_idx[i] == 1);
         s_tlp_eop[p]   = (src_idx[i] + 1 == src_len[i]);
         sd[p]          = cur_d[i];
         ss[p]          = cur_s[i];
         sh[p]          = cur_h[i];
      end
      if (rdy_low != 0) begin
         m_tlp_ready = 1'b0;
         rdy_low--;
      end else begin
         m_tlp_ready = ($urandom_range(99) < rdy_pct);
      end
      model();
   endtask

   function automatic bit busy();
      bit r;
      r = md_locked;
      for (int i = 0; i < P; i++) r = r | src_on[i];
      return r;
   endfunction

   task automatic drain(input int max_cycles, input string tag);
      int n;
      n = 0;
      while (busy() && n < max_cycles) begin
         step();
         n++;
      end
      total++;
      if (busy()) begin
         bad++;
         $display("FAIL drain_%s: still busy after %0d cycles, required idle", tag, n);
      end
      step();
   endtask

   always @(negedge clk) begin
      if (stat_q.size() != 0) begin
         stat_t e;
         logic [SBW-1:0] a, r;
         logic idlenz;
         e      = stat_q.pop_front();
         idlenz = !e.act && ({m_tlp_data, m_tlp_strb, m_tlp_hdr, m_tlp_sop, m_tlp_eop} !== '0);
         a = {s_tlp_ready, m_tlp_valid, grant_active, grant_id, sop_err, idlenz};
         r = {e.rdy, e.vld, e.act, e.gid, e.err, 1'b0};
         total++;
         if (a !== r) begin
            bad++;
            $display("FAIL status @%0t: rdy/vld/act/gid/err/idle_nonzero got %b required %b", $time, a, r);
         end
`ifdef PCIE_TLP_ARB_PKT_CNT_EN
         total++;
         if (pkt_cnt !== e.cnt) begin
            bad++;
            $display("FAIL pkt_cnt @%0t: got %h required %h", $time, pkt_cnt, e.cnt);
         end
`endif
      end
      if (m_tlp_valid === 1'b1 && m_tlp_ready === 1'b1) begin
         total++;
         if (beat_q.size() == 0) begin
            bad++;
            $display("FAIL beat_extra @%0t: got transfer from gid=%0d data=%h, required none", $time, grant_id, m_tlp_data);
         end else begin
            beat_t b;
            logic [BW-1:0] ab, rb;
            b  = beat_q.pop_front();
            ab = {m_tlp_data, m_tlp_strb, m_tlp_hdr, m_tlp_sop, m_tlp_eop, grant_id};
            rb = {b.d, b.s, b.h, b.sop, b.eop, b.gid};
            if (ab !== rb) begin
               bad++;
               $display("FAIL beat @%0t: data/strb/hdr/sop/eop/gid got %h required %h", $time, ab, rb);
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < P; i++) begin
         src_on[i]  = 1'b0;
         src_len[i] = 1;
         src_idx[i] = 0;
         md_cnt[i]  = 0;
         new_beat(i);
      end

      rst_cmd = 1'b1;
      repeat (3) step();
      rst_cmd = 1'b0;

      // two single-beat requests at once: port 0 first, port 2 after one bubble
      start_pkt(0, 1, 1'b0, 1'b0);
      start_pkt(2, 1, 1'b0, 1'b0);
      drain(20, "two_single");

      // port 1 packet stays atomic while port 3 keeps requesting
      start_pkt(1, 3, 1'b0, 1'b0);
      step();
      start_pkt(3, 2, 1'b0, 1'b0);
      drain(30, "atomic");

      // all ports streaming single-beat packets
      auto_pct = 100;
      auto_max = 1;
      repeat (14) step();
      auto_pct = 0;
      drain(30, "all_valid");

      // sink stalls mid-packet
      start_pkt(2, 4, 1'b0, 1'b0);
      step();
      step();
      rdy_low = 5;
      drain(30, "stall");

      // missing sop on first beat, then stray sop on a middle beat
      start_pkt(1, 2, 1'b1, 1'b0);
      drain(20, "bad_first");
      start_pkt(3, 3, 1'b0, 1'b1);
      drain(20, "bad_mid");

      // reset after two beats of a four-beat packet
      start_pkt(0, 4, 1'b0, 1'b0);
      begin
         int n;
         n = 0;
         while (src_idx[0] < 2 && n < 40) begin
            step();
            n++;
         end
         total++;
         if (src_idx[0] < 2) begin
            bad++;
            $display("FAIL mid_pkt_wait: beats sent %0d, required 2", src_idx[0]);
         end
      end
      rst_cmd = 1'b1;
      step();
      rst_cmd = 1'b0;
      step();
      start_pkt(3, 1, 1'b0, 1'b0);
      start_pkt(0, 1, 1'b0, 1'b0);
      drain(20, "after_reset");

      // random traffic with valid drops and sink backpressure
      auto_pct = 30;
      auto_max = 5;
      drop_pct = 20;
      rdy_pct  = 70;
      repeat (1500) step();
      auto_pct = 0;
      drop_pct = 0;
      rdy_pct  = 100;
      drain(300, "random");

      @(negedge clk);
      @(negedge clk);
      total++;
      if (beat_q.size() != 0) begin
         bad++;
         $display("FAIL beats_left: got %0d unsent beats, required 0", beat_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pcie_tlp_req_arb.md
PCIE_TLP_REQ_ARB -- requirements
Module: pcie_tlp_req_arb

Interface
REQ-001 Parameter PORTS, default 4: number of TLP request sources, 2..8.
REQ-002 Parameter TLP_DATA_WIDTH, default 256: payload width per beat.
REQ-003 Parameter TLP_STRB_WIDTH, default 8: dword-strobe width per beat.
REQ-004 Parameter TLP_HDR_WIDTH, default 128: header width.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 Port s_tlp_data, input, PORTS*TLP_DATA_WIDTH: source payloads; port i occupies slice i.
REQ-008 Port s_tlp_strb, input, PORTS*TLP_STRB_WIDTH: source strobes.
REQ-009 Port s_tlp_hdr, input, PORTS*TLP_HDR_WIDTH: source headers, valid on sop beats.
REQ-010 Ports s_tlp_valid, s_tlp_sop and s_tlp_eop, input, PORTS each: per-source beat qualifiers.
REQ-011 Port s_tlp_ready, output, PORTS: per-source accept.
REQ-012 Ports m_tlp_data, m_tlp_strb and m_tlp_hdr, output, single-port widths: arbitrated stream into the RAM bridge rx_req interface.
REQ-013 Ports m_tlp_valid, m_tlp_sop and m_tlp_eop, output, 1 bit each: arbitrated qualifiers.
REQ-014 Port m_tlp_ready, input, 1 bit: sink accept.
REQ-015 Port grant_id, output, clog2(PORTS): index of the currently locked port.
REQ-016 Port grant_active, output, 1 bit: high while in LOCKED.
REQ-017 Port sop_err, output, 1 bit: single-cycle pulse on a protocol violation.

Function
REQ-018 The FSM SHALL have two states, IDLE and LOCKED.
REQ-019 In IDLE with any s_tlp_valid high, the arbiter SHALL select round-robin, starting at last_grant+1 (mod PORTS), register grant_id, and enter LOCKED on the next cycle.
REQ-020 In IDLE, m_tlp_valid and all s_tlp_ready SHALL be 0.
REQ-021 In LOCKED, the m_tlp_* outputs SHALL combinationally equal the granted port's inputs.
REQ-022 In LOCKED, s_tlp_ready[grant_id] SHALL equal m_tlp_ready, and all other ready bits SHALL be 0.
REQ-023 A beat SHALL transfer when m_tlp_valid and m_tlp_ready are both high.
REQ-024 A transfer with eop=1 SHALL return the FSM to IDLE and set last_grant=grant_id.
REQ-025 Packets SHALL be atomic: no grant change between sop and eop, whatever other requests are pending.
REQ-026 Arbitration latency SHALL be 1 cycle, with one IDLE bubble between consecutive packets.
REQ-027 A single-beat packet (sop=1 and eop=1) SHALL occupy exactly one LOCKED transfer.
REQ-028 The first transferred beat of a grant with sop=0 SHALL pulse sop_err; the beat SHALL still pass through.
REQ-029 A beat with sop=1 after the first beat of a grant SHALL also pulse sop_err.
REQ-030 A granted source dropping valid mid-packet SHALL keep the lock; the arbiter SHALL wait with no timeout.
REQ-031 Valid deasserted on non-granted ports SHALL have no effect on the lock.

Reset
REQ-032 On rst, the block SHALL enter IDLE with last_grant=PORTS-1, so port 0 has first priority.
REQ-033 On rst, grant_id and grant_active SHALL be 0, and sop_err SHALL be 0.
REQ-034 Reset asserted mid-packet SHALL abandon the packet; the next grant SHALL require a new request.

Configuration
REQ-035 With macro PCIE_TLP_ARB_PKT_CNT_EN defined, the block SHALL add output pkt_cnt (PORTS*16 bits).
REQ-036 pkt_cnt SHALL hold per-port counts of completed packets (eop transfers), saturating at 0xFFFF and cleared by rst.
REQ-037 With PCIE_TLP_ARB_PKT_CNT_EN undefined, the port and the counters SHALL be absent.

Structure
REQ-038 The FSM state enum and the width constants SHALL reside in the shared package pcie_tlp_pkg.
REQ-039 Round-robin selection SHALL be the sub-module rr_select (request vector plus last_grant in, one-hot grant out).

Verification
REQ-040 Ports 0 and 2 each present a 1-beat packet at cycle 0, m_tlp_ready=1 -> port 0 transfers in cycle 1, IDLE in cycle 2, port 2 transfers in cycle 3.
REQ-041 Port 1 sends a 3-beat packet while port 3 is valid throughout -> all 3 beats come from port 1, and grant_id does not change until after eop.
REQ-042 All 4 ports continuously valid with 1-beat packets -> grant order is 0,1,2,3,0.
REQ-043 m_tlp_ready held low for 5 cycles during a locked packet -> outputs hold stable, s_tlp_ready is 0 on all ports, no beat is lost.
REQ-044 First beat of a grant has sop=0 -> sop_err=1 for exactly 1 cycle and the data passes through.
REQ-045 rst asserted after beat 2 of a 4-beat packet -> next cycle is IDLE with outputs 0; port 0 wins the next arbitration; pkt_cnt (when enabled) reads 0.
